// File: rtl/uart_aes_cmd_ctrl.sv
// Command sequencer between the UART receiver/transmitter and the AES core.
// Receives a command byte and a 16-byte payload, loads the key or the
// plaintext, runs the AES core and streams the ciphertext back out one byte
// at a time. Unknown commands, timeouts and dropped bytes are answered with
// an err pulse, and a NAK byte is sent when the command or payload fails.
//
// Handshake semantics: rx_done is a one-cycle strobe that qualifies rx_byte
// and has no back-pressure. Bytes arriving outside IDLE/LOAD are dropped and
// flagged on err. tx_start is a one-cycle strobe that is issued only while
// tx_busy is low. tx_byte is held from tx_start until tx_busy falls again.
// aes_start/aes_done form a request/complete pulse pair. aes_ct is sampled
// only on aes_done while the block is waiting for it.
module uart_aes_cmd_ctrl #(
  parameter logic [15:0] TIMEOUT_TICKS = 16'd4096,
  parameter logic [7:0]  CMD_KEY       = 8'h4B,
  parameter logic [7:0]  CMD_ENC       = 8'h50
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_done,
  input  logic         s_tick,
  output logic [127:0] aes_key,
  output logic [127:0] aes_pt,
  output logic         aes_start,
  input  logic         aes_done,
  input  logic [127:0] aes_ct,
  output logic [7:0]   tx_byte,
  output logic         tx_start,
  input  logic         tx_busy,
  output logic         busy,
  output logic         err
);

  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, LOAD, AES_GO, AES_WAIT, TX_SEND, TX_GUARD, TX_WAIT
  } state_t;

  state_t         state, state_d;
  logic [3:0]     byte_cnt, byte_cnt_d;
  logic [15:0]    tmo_cnt, tmo_cnt_d;
  logic [15:0]    tmo_inc;
  logic           is_key, is_key_d;     // command latched in IDLE
  logic           is_ct, is_ct_d;       // 1: ciphertext stream, 0: ACK/NAK
  logic [7:0]     resp, resp_d;
  logic [127:0]   ct_shift, ct_shift_d;
  logic [4:0]     rem_cnt, rem_cnt_d;
  logic [127:0]   aes_key_d, aes_pt_d;
  logic [7:0]     tx_byte_d;
  logic           aes_start_d, tx_start_d, err_d, busy_d;

  assign tmo_inc = tmo_cnt + 16'd1;

  // Next-state and next-output computation; all outputs are registered.
  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    tmo_cnt_d   = tmo_cnt;
    is_key_d    = is_key;
    is_ct_d     = is_ct;
    resp_d      = resp;
    ct_shift_d  = ct_shift;
    rem_cnt_d   = rem_cnt;
    aes_key_d   = aes_key;
    aes_pt_d    = aes_pt;
    tx_byte_d   = tx_byte;
    aes_start_d = 1'b0;
    tx_start_d  = 1'b0;
    err_d       = 1'b0;

    case (state)
      IDLE: begin
        if (rx_done) begin
          if (rx_byte == CMD_KEY || rx_byte == CMD_ENC) begin
            is_key_d   = (rx_byte == CMD_KEY);
            byte_cnt_d = 4'd0;
            tmo_cnt_d  = 16'd0;
            state_d    = LOAD;
          end else begin
            resp_d  = NAK;
            is_ct_d = 1'b0;
            err_d   = 1'b1;
            state_d = TX_SEND;
          end
        end
      end
      LOAD: begin
        if (rx_done) begin
          if (is_key) aes_key_d = {aes_key[119:0], rx_byte};
          else        aes_pt_d  = {aes_pt[119:0], rx_byte};
          byte_cnt_d = byte_cnt + 4'd1;
          tmo_cnt_d  = 16'd0;
          if (byte_cnt == 4'd15) begin
            if (is_key) begin
              resp_d  = ACK;
              is_ct_d = 1'b0;
              state_d = TX_SEND;
            end else begin
              state_d = AES_GO;
            end
          end
        end else if (s_tick) begin
          tmo_cnt_d = tmo_inc;
          if (tmo_inc == TIMEOUT_TICKS) begin
            err_d     = 1'b1;
            resp_d    = NAK;
            is_ct_d   = 1'b0;
            tmo_cnt_d = 16'd0;
            state_d   = TX_SEND;
          end
        end
      end
      AES_GO: begin
        aes_start_d = 1'b1;
        state_d     = AES_WAIT;
      end
      AES_WAIT: begin
        if (aes_done) begin
          ct_shift_d = aes_ct;
          rem_cnt_d  = 5'd16;
          is_ct_d    = 1'b1;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!tx_busy) begin
          tx_byte_d  = is_ct ? ct_shift[127:120] : resp;
          tx_start_d = 1'b1;
          state_d    = TX_GUARD;
        end
      end
      TX_GUARD: begin
        // tx_busy has not risen yet in this cycle, so it is not looked at.
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          if (is_ct) begin
            ct_shift_d = {ct_shift[119:0], 8'h00};
            rem_cnt_d  = rem_cnt - 5'd1;
            state_d    = (rem_cnt == 5'd1) ? IDLE : TX_SEND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Bytes that arrive while the block is busy elsewhere are lost.
    if (rx_done && state != IDLE && state != LOAD) err_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_cnt  <= 4'd0;
      tmo_cnt   <= 16'd0;
      is_key    <= 1'b0;
      is_ct     <= 1'b0;
      resp      <= 8'h00;
      ct_shift  <= 128'd0;
      rem_cnt   <= 5'd0;
      aes_key   <= 128'd0;
      aes_pt    <= 128'd0;
      tx_byte   <= 8'h00;
      aes_start <= 1'b0;
      tx_start  <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      byte_cnt  <= byte_cnt_d;
      tmo_cnt   <= tmo_cnt_d;
      is_key    <= is_key_d;
      is_ct     <= is_ct_d;
      resp      <= resp_d;
      ct_shift  <= ct_shift_d;
      rem_cnt   <= rem_cnt_d;
      aes_key   <= aes_key_d;
      aes_pt    <= aes_pt_d;
      tx_byte   <= tx_byte_d;
      aes_start <= aes_start_d;
      tx_start  <= tx_start_d;
      err       <= err_d;
      busy      <= busy_d;
    end
  end

endmodule
